// File: rtl/serial_stim_pkg.sv
// Shared types and sizing helpers for the serial stimulus driver.
package serial_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Largest frame and idle gap the internal counters are sized for.
    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned MAX_GAP   = 65535;

    // Bits needed to hold the values 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Bit counter spans 0..MAX_WIDTH-1, gap counter spans 0..MAX_GAP-1.
    localparam int unsigned BIT_CNT_W = cnt_w(MAX_WIDTH - 1);
    localparam int unsigned GAP_CNT_W = cnt_w(MAX_GAP - 1);

endpackage

// File: rtl/serial_stim_driver_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Clear has priority over increment; increment stops at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/serial_stim_driver.sv
// Serialises a handshaked parallel word onto x, counts the downstream
// recogniser's F responses over the frame and reports them with a done pulse.
module serial_stim_driver
    import serial_stim_pkg::*;
#(
    parameter  int unsigned WIDTH      = 8,
    parameter  bit          MSB_FIRST  = 1'b1,
    parameter  int unsigned GAP_CYCLES = 2,
    parameter  bit          IDLE_LEVEL = 1'b0,
    localparam int unsigned CW         = cnt_w(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             x,
    output logic             x_valid,
    input  logic             f_in,
    output logic [CW-1:0]    hit_count,
    output logic             done,
    output logic             busy
);

    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST =
        GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_shift;
    logic [WIDTH-1:0]       w_shifted;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [GAP_CNT_W-1:0]   r_gap_cnt;
    logic                   r_x;
    logic                   r_x_valid;
    logic                   r_xv_d;
    logic                   r_done;
    logic                   w_in_ready;
    logic                   w_busy;
    logic                   w_accept;
    logic                   w_last_bit;
    logic                   w_gap_done;
    logic                   w_hit;

    // Bit that goes out next from the current shift-register contents.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    // Drops the bit just sent so the next one sits at the head.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    assign w_shifted  = advance(r_shift);
    assign w_last_bit = (r_bit_cnt == BIT_LAST);
    assign w_gap_done = (r_gap_cnt == GAP_LAST);
    assign w_accept   = in_valid & w_in_ready;

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE -> SHIFT -> DRAIN -> (GAP) -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_state_nxt = SHIFT;
            SHIFT:   if (w_last_bit) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (w_gap_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        w_in_ready = (r_state == IDLE);
        w_busy     = (r_state != IDLE);
    end

    // Shift register, bit/gap counters and the registered serial outputs.
    // x is loaded one edge ahead so frame bit k is on the pin in cycle k.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_x       <= IDLE_LEVEL;
            r_x_valid <= 1'b0;
            r_xv_d    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_xv_d <= r_x_valid;
            r_done <= (r_state == DRAIN);

            if (w_accept) begin
                r_shift   <= in_data;
                r_bit_cnt <= '0;
                r_x       <= head_bit(in_data);
                r_x_valid <= 1'b1;
            end else if (r_state == SHIFT) begin
                r_shift   <= w_shifted;
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (w_last_bit) begin
                    r_x       <= IDLE_LEVEL;
                    r_x_valid <= 1'b0;
                end else begin
                    r_x       <= head_bit(w_shifted);
                    r_x_valid <= 1'b1;
                end
            end else begin
                r_x       <= IDLE_LEVEL;
                r_x_valid <= 1'b0;
            end

            if (r_state == DRAIN) begin
                r_gap_cnt <= '0;
            end else if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    // F lags its x bit by one cycle, so the sample window is x_valid delayed.
    assign w_hit = r_xv_d & f_in;

    sat_counter #(
        .W (CW)
    ) u_hit_cnt (
        .clk   (CLK),
        .rst_n (RESET),
        .clr   (w_accept),
        .inc   (w_hit),
        .q     (hit_count)
    );

    assign in_ready = w_in_ready;
    assign busy     = w_busy;
    assign x        = r_x;
    assign x_valid  = r_x_valid;
    assign done     = r_done;

endmodule
